// File: rtl/ffstdp_pkg.sv
// Shared definitions for the FF-STDP synaptic update sweep.
// FFSTDP_UPD_LAT is the SRAM read cycle plus the datapath register stage.
package ffstdp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ffstdp_state_t;

    localparam int FFSTDP_UPD_LAT = 2;

endpackage

// File: rtl/ffstdp_issue_pipe.sv
// {valid, addr} delay line tracking issued reads until their write-back slot.
// Address stages load only on a valid entry, so the output address holds through gaps.
module ffstdp_issue_pipe #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = ffstdp_pkg::FFSTDP_UPD_LAT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    input  logic [ADDR_WIDTH-1:0] IN_ADDR,
    output logic                  OUT_VALID,
    output logic [ADDR_WIDTH-1:0] OUT_ADDR,
    output logic                  PEND
);

    logic [DEPTH-1:0]      valid_q;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= IN_VALID;
            if (IN_VALID) begin
                addr_q[0] <= IN_ADDR;
            end
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    addr_q[i] <= addr_q[i-1];
                end
            end
        end
    end

    // PEND: something is still upstream of the final stage.
    always_comb begin
        PEND = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            PEND = PEND | valid_q[i];
        end
    end

    assign OUT_VALID = valid_q[DEPTH-1];
    assign OUT_ADDR  = addr_q[DEPTH-1];

endmodule

// File: rtl/ffstdp_sweep_ctrl.sv
// Walks every {pre, post} synapse address, one read per cycle, and aligns
// write-back, count selects and update enable with the datapath register stage.
//
//   state    | meaning
//   ST_IDLE  | waiting for START; latches polarity/mode on accept
//   ST_SWEEP | issuing one read per unpaused cycle
//   ST_DRAIN | no reads; waiting for in-flight updates to write back
//   ST_DONE  | one-cycle DONE pulse, then back to idle
module ffstdp_sweep_ctrl
    import ffstdp_pkg::*;
#(
    parameter int PRE_NUM    = 256,
    parameter int POST_NUM   = 256,
    parameter int ADDR_WIDTH = $clog2(PRE_NUM * POST_NUM)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        START,
    input  logic                        IS_POS_IN,
    input  logic                        IS_TRAIN_IN,
    input  logic                        PAUSE,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        SRAM_RE,
    output logic [ADDR_WIDTH-1:0]       SRAM_RADDR,
    output logic                        SRAM_WE,
    output logic [ADDR_WIDTH-1:0]       SRAM_WADDR,
    output logic [$clog2(PRE_NUM)-1:0]  PRE_IDX,
    output logic [$clog2(POST_NUM)-1:0] POST_IDX,
    output logic                        UPD_EN,
    output logic                        IS_POS,
    output logic                        IS_TRAIN
);

    localparam int PRE_W  = $clog2(PRE_NUM);
    localparam int POST_W = $clog2(POST_NUM);

    ffstdp_state_t         state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  accept;
    logic                  issue;
    logic                  pipe_vld;
    logic                  pipe_pend;
    logic [ADDR_WIDTH-1:0] pipe_addr;
    logic                  is_pos_q;
    logic                  is_train_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                BUSY  = 1'b1;
                issue = ~PAUSE;
                if (issue && (cnt == {ADDR_WIDTH{1'b1}})) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                BUSY = 1'b1;
                // Last stage is writing this cycle; nothing behind it means empty next cycle.
                if (!pipe_pend) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                DONE      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt        <= '0;
            is_pos_q   <= 1'b0;
            is_train_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt        <= '0;
                is_pos_q   <= IS_POS_IN;
                is_train_q <= IS_TRAIN_IN;
            end else if (issue) begin
                cnt <= cnt + ADDR_WIDTH'(1);
            end
        end
    end

    ffstdp_issue_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (FFSTDP_UPD_LAT)
    ) u_issue_pipe (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (issue),
        .IN_ADDR   (cnt),
        .OUT_VALID (pipe_vld),
        .OUT_ADDR  (pipe_addr),
        .PEND      (pipe_pend)
    );

    assign SRAM_RE    = issue;
    assign SRAM_RADDR = cnt;
    assign SRAM_WE    = pipe_vld;
    assign UPD_EN     = pipe_vld;
    assign SRAM_WADDR = pipe_addr;
    assign PRE_IDX    = pipe_addr[POST_W +: PRE_W];
    assign POST_IDX   = pipe_addr[POST_W-1:0];
    assign IS_POS     = is_pos_q;
    assign IS_TRAIN   = is_train_q;

endmodule

// File: tb/tb_ffstdp_sweep_ctrl.sv
// Directed bench for ffstdp_sweep_ctrl at PRE_NUM = POST_NUM = 4 (16 synapses).
// Cycle t: inputs driven at negedge of t, outputs sampled 1 ns later.
module tb_ffstdp_sweep_ctrl;

    localparam int PRE_NUM  = 4;
    localparam int POST_NUM = 4;
    localparam int AW       = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          IS_POS_IN = 1'b0;
    logic          IS_TRAIN_IN = 1'b0;
    logic          PAUSE = 1'b0;
    logic          BUSY, DONE, SRAM_RE, SRAM_WE, UPD_EN, IS_POS, IS_TRAIN;
    logic [AW-1:0] SRAM_RADDR, SRAM_WADDR;
    logic [1:0]    PRE_IDX, POST_IDX;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    ffstdp_sweep_ctrl #(
        .PRE_NUM  (PRE_NUM),
        .POST_NUM (POST_NUM)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .IS_POS_IN   (IS_POS_IN),
        .IS_TRAIN_IN (IS_TRAIN_IN),
        .PAUSE       (PAUSE),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .SRAM_RE     (SRAM_RE),
        .SRAM_RADDR  (SRAM_RADDR),
        .SRAM_WE     (SRAM_WE),
        .SRAM_WADDR  (SRAM_WADDR),
        .PRE_IDX     (PRE_IDX),
        .POST_IDX    (POST_IDX),
        .UPD_EN      (UPD_EN),
        .IS_POS      (IS_POS),
        .IS_TRAIN    (IS_TRAIN)
    );

    // Read/write collision watch, sampled mid-cycle.
    always @(negedge CLK) begin
        #2;
        if (!RST && SRAM_RE === 1'b1 && SRAM_WE === 1'b1) begin
            vectors++;
            if (SRAM_WADDR === SRAM_RADDR) begin
                miscompares++;
                $display("FAIL rw_overlap addr got=%0d must differ from raddr=%0d", SRAM_WADDR, SRAM_RADDR);
            end
        end
    end

    task automatic test_reset();
        logic [18:0] all_out;
        RST = 1'b1; START = 1'b1; PAUSE = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        all_out = {BUSY, DONE, SRAM_RE, SRAM_RADDR, SRAM_WE, SRAM_WADDR,
                   PRE_IDX, POST_IDX, UPD_EN, IS_POS, IS_TRAIN};
        vectors++;
        if (all_out !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h exp=0", all_out);
        end
        @(negedge CLK);
        RST = 1'b0; START = 1'b0; PAUSE = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        vectors++;
        if ({BUSY, SRAM_RE, SRAM_WE} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_idle got=%b exp=000", {BUSY, SRAM_RE, SRAM_WE});
        end
    endtask

    task automatic test_plain();
        logic [6:0] ctl, exp_ctl;
        logic [7:0] wobs, wexp;
        logic [3:0] wa;
        for (int t = 0; t <= 21; t++) begin
            @(negedge CLK);
            START = (t == 0); IS_POS_IN = 1'b1; IS_TRAIN_IN = 1'b0; PAUSE = 1'b0;
            #1;
            if (t > 0) begin
                exp_ctl = {1'(t <= 18), 1'(t == 19), 1'(t <= 16),
                           1'(t >= 3 && t <= 18), 1'(t >= 3 && t <= 18), 1'b1, 1'b0};
                ctl = {BUSY, DONE, SRAM_RE, SRAM_WE, UPD_EN, IS_POS, IS_TRAIN};
                vectors++;
                if (ctl !== exp_ctl) begin
                    miscompares++;
                    $display("FAIL plain_ctl t=%0d got=%b exp=%b", t, ctl, exp_ctl);
                end
                if (t <= 16) begin
                    vectors++;
                    if (SRAM_RADDR !== 4'(t - 1)) begin
                        miscompares++;
                        $display("FAIL plain_raddr t=%0d got=%0d exp=%0d", t, SRAM_RADDR, t - 1);
                    end
                end
                if (t >= 3) begin
                    wa   = (t <= 18) ? 4'(t - 3) : 4'd15;
                    wexp = {wa, wa[3:2], wa[1:0]};
                    wobs = {SRAM_WADDR, PRE_IDX, POST_IDX};
                    vectors++;
                    if (wobs !== wexp) begin
                        miscompares++;
                        $display("FAIL plain_waddr_idx t=%0d got=%h exp=%h", t, wobs, wexp);
                    end
                end
            end
        end
    endtask

    task automatic test_pause();
        logic [6:0] ctl, exp_ctl;
        logic [7:0] wobs, wexp;
        logic [3:0] wa;
        logic       ere, ewe;
        for (int t = 0; t <= 24; t++) begin
            @(negedge CLK);
            START = (t == 0); IS_POS_IN = 1'b1; IS_TRAIN_IN = 1'b0;
            PAUSE = (t >= 5 && t <= 7);
            #1;
            if (t > 0) begin
                ere = (t <= 19) && !(t >= 5 && t <= 7);
                ewe = (t >= 3 && t <= 6) || (t >= 10 && t <= 21);
                exp_ctl = {1'(t <= 21), 1'(t == 22), ere, ewe, ewe, 1'b1, 1'b0};
                ctl = {BUSY, DONE, SRAM_RE, SRAM_WE, UPD_EN, IS_POS, IS_TRAIN};
                vectors++;
                if (ctl !== exp_ctl) begin
                    miscompares++;
                    $display("FAIL pause_ctl t=%0d got=%b exp=%b", t, ctl, exp_ctl);
                end
                if (ere) begin
                    vectors++;
                    if (SRAM_RADDR !== ((t < 5) ? 4'(t - 1) : 4'(t - 4))) begin
                        miscompares++;
                        $display("FAIL pause_raddr t=%0d got=%0d", t, SRAM_RADDR);
                    end
                end
                if (t >= 3) begin
                    wa = (t <= 6) ? 4'(t - 3) : (t <= 9) ? 4'd3 : (t <= 21) ? 4'(t - 6) : 4'd15;
                    wexp = {wa, wa[3:2], wa[1:0]};
                    wobs = {SRAM_WADDR, PRE_IDX, POST_IDX};
                    vectors++;
                    if (wobs !== wexp) begin
                        miscompares++;
                        $display("FAIL pause_waddr_idx t=%0d got=%h exp=%h", t, wobs, wexp);
                    end
                end
            end
        end
        PAUSE = 1'b0;
    endtask

    task automatic test_start_ignored();
        int wr_cnt   = 0;
        int done_cnt = 0;
        for (int t = 0; t <= 26; t++) begin
            @(negedge CLK);
            START       = (t == 0 || t == 4 || t == 18 || t == 19);
            IS_POS_IN   = (t != 0);
            IS_TRAIN_IN = (t == 0);
            PAUSE       = 1'b0;
            #1;
            if (t > 0) begin
                if (SRAM_WE === 1'b1) begin
                    vectors++;
                    if (SRAM_WADDR !== 4'(wr_cnt)) begin
                        miscompares++;
                        $display("FAIL ign_wr_order t=%0d got=%0d exp=%0d", t, SRAM_WADDR, wr_cnt);
                    end
                    wr_cnt++;
                end
                if (DONE === 1'b1) done_cnt++;
                vectors++;
                if ({IS_POS, IS_TRAIN, DONE, BUSY} !== {1'b0, 1'b1, 1'(t == 19), 1'(t <= 18)}) begin
                    miscompares++;
                    $display("FAIL ign_state t=%0d got=%b exp=%b", t, {IS_POS, IS_TRAIN, DONE, BUSY},
                             {1'b0, 1'b1, 1'(t == 19), 1'(t <= 18)});
                end
            end
        end
        vectors++;
        if (wr_cnt != 16 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL ign_counts got writes=%0d dones=%0d exp writes=16 dones=1", wr_cnt, done_cnt);
        end
        START = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [18:0] all_out;
        for (int t = 0; t <= 15; t++) begin
            @(negedge CLK);
            START = (t == 0); IS_POS_IN = 1'b1; IS_TRAIN_IN = 1'b1; PAUSE = 1'b0;
            if (t == 10) begin
                #1;
                vectors++;
                if ({SRAM_WE, SRAM_WADDR} !== {1'b1, 4'd7}) begin
                    miscompares++;
                    $display("FAIL rstmid_inflight got=%b/%0d exp=1/7", SRAM_WE, SRAM_WADDR);
                end
                RST = 1'b1;
            end
            if (t == 12) RST = 1'b0;
            #1;
            if (t >= 10) begin
                all_out = {BUSY, DONE, SRAM_RE, SRAM_RADDR, SRAM_WE, SRAM_WADDR,
                           PRE_IDX, POST_IDX, UPD_EN, IS_POS, IS_TRAIN};
                vectors++;
                if (all_out !== 19'd0) begin
                    miscompares++;
                    $display("FAIL rstmid_zero t=%0d got=%h exp=0", t, all_out);
                end
            end
        end
        test_plain();
    endtask

    task automatic test_back_to_back();
        logic [6:0] ctl, exp_ctl;
        int         u;
        for (int t = 0; t <= 40; t++) begin
            @(negedge CLK);
            START       = (t == 0 || t == 20);
            IS_POS_IN   = (t < 20);
            IS_TRAIN_IN = (t >= 20);
            PAUSE       = 1'b0;
            #1;
            if (t > 0) begin
                u = (t <= 20) ? t : t - 20;
                if (t == 20)
                    exp_ctl = 7'b0000010;
                else
                    exp_ctl = {1'(u <= 18), 1'(u == 19), 1'(u <= 16), 1'(u >= 3 && u <= 18),
                               1'(u >= 3 && u <= 18), 1'(t < 20), 1'(t > 20)};
                ctl = {BUSY, DONE, SRAM_RE, SRAM_WE, UPD_EN, IS_POS, IS_TRAIN};
                vectors++;
                if (ctl !== exp_ctl) begin
                    miscompares++;
                    $display("FAIL b2b_ctl t=%0d got=%b exp=%b", t, ctl, exp_ctl);
                end
                if (t != 20 && u <= 16) begin
                    vectors++;
                    if (SRAM_RADDR !== 4'(u - 1)) begin
                        miscompares++;
                        $display("FAIL b2b_raddr t=%0d got=%0d exp=%0d", t, SRAM_RADDR, u - 1);
                    end
                end
                if (t != 20 && u >= 3 && u <= 18) begin
                    vectors++;
                    if (SRAM_WADDR !== 4'(u - 3)) begin
                        miscompares++;
                        $display("FAIL b2b_waddr t=%0d got=%0d exp=%0d", t, SRAM_WADDR, u - 3);
                    end
                end
            end
        end
        START = 1'b0;
    endtask

    initial begin
        test_reset();
        test_plain();
        test_pause();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ffstdp_sweep_ctrl.md
# ffstdp_sweep_ctrl

Sequencer for the FF-STDP synaptic update datapath. On a start request it walks every (pre, post) synapse address in synapse SRAM. For each address it issues a read, aligns the neuron spike-count selects and the update enable with the datapath's one-cycle register stage, and writes the new weight/gradient back. It sits between the top-level time-reference controller, the synapse SRAM (separate read and write ports) and `ffstdp_update`, and sustains one synapse per cycle.

## Interface
- `PRE_NUM`, 256: number of presynaptic neurons (power of 2, ≥2).
- `POST_NUM`, 256: number of postsynaptic neurons (power of 2, ≥2).
- `ADDR_WIDTH`, $clog2(PRE_NUM*POST_NUM): synapse SRAM address width; address = {pre_idx, post_idx}.

Ports:
- `CLK` in 1: single clock. Everything is rising-edge.
- `RST` in 1: asynchronous, active-high reset.
- `START` in 1: one-cycle request to sweep. Accepted only in IDLE.
- `IS_POS_IN` in 1: sample polarity. Latched on an accepted START.
- `IS_TRAIN_IN` in 1: train/accumulate mode. Latched on an accepted START.
- `PAUSE` in 1: host/SPI arbitration stall. Blocks new read issue.
- `BUSY` out 1: sweep in progress.
- `DONE` out 1: one-cycle pulse after the last write.
- `SRAM_RE` out 1: read enable.
- `SRAM_RADDR` out ADDR_WIDTH: read address.
- `SRAM_WE` out 1: write enable.
- `SRAM_WADDR` out ADDR_WIDTH: write address.
- `PRE_IDX` out $clog2(PRE_NUM): pre-count mux select, aligned to the datapath output stage.
- `POST_IDX` out $clog2(POST_NUM): post-count mux select, aligned to the datapath output stage.
- `UPD_EN` out 1: drives `CTRL_TREF_EVENT` of the datapath.
- `IS_POS` out 1: latched polarity to the datapath.
- `IS_TRAIN` out 1: latched mode to the datapath.

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - START=1 latches IS_POS/IS_TRAIN, clears the address counter, and moves to SWEEP.
  - START in any other state is ignored. It is not queued.
- SWEEP:
  - Each cycle with PAUSE=0: SRAM_RE=1, SRAM_RADDR=counter, then counter increments.
  - Counter order: post index inner, pre index outer. Plain binary increment of {pre, post}.
  - Issuing address PRE_NUM*POST_NUM-1 moves to DRAIN. The counter wraps to 0 and is not used again.
  - PAUSE=1: SRAM_RE=0 and the counter holds. Operations already in flight still complete, because the datapath registers are unconditional.
- DRAIN: no reads. Stays until the 2-stage issue pipeline is empty, then moves to DONE.
- DONE: DONE=1 for one cycle, then IDLE.
- Issue pipeline: 2-stage shift of {valid, addr}.
  - Stage-2 valid drives SRAM_WE and UPD_EN.
  - Stage-2 addr drives SRAM_WADDR, PRE_IDX (upper bits) and POST_IDX (lower bits).
  - When stage-2 valid=0: SRAM_WE=0 and UPD_EN=0. PRE_IDX/POST_IDX hold their last value.
- IS_POS/IS_TRAIN stay constant from accepted START until the next accepted START.
- BUSY=1 in SWEEP and DRAIN. BUSY=0 in IDLE and DONE.
- Reset mid-sweep: all outputs return to reset values immediately. In-flight writes are dropped (SRAM_WE forced 0). No DONE pulse.
- Reset values: state=IDLE. Every output is 0: BUSY, DONE, SRAM_RE, SRAM_RADDR, SRAM_WE, SRAM_WADDR, PRE_IDX, POST_IDX, UPD_EN, IS_POS, IS_TRAIN. Counter and pipeline valids are also 0.

## Timing
- Let cycle 0 be the cycle in which START is sampled high in IDLE.
- Read of address k is issued at cycle 1+k+p, where p = PAUSE cycles seen so far.
- SRAM data is valid the following cycle. The datapath registers it at the end of that cycle.
- Write of address k: two cycles after its read, with SRAM_WE=UPD_EN=1 and indices equal to k.
- With no PAUSE and N = PRE_NUM*POST_NUM:
  - Last read at cycle N.
  - Last write at cycle N+2.
  - DONE at cycle N+3.
  - BUSY high over cycles 1..N+2.
- Read and write to the same address never overlap: write address always trails read address by ≥2 issued addresses or by idle slots.
- PAUSE has a combinational effect on SRAM_RE in the same cycle. PAUSE in IDLE/DRAIN/DONE has no effect.

## Structure
- Shared package `ffstdp_pkg`:
  - State encoding enum.
  - Pipeline depth constant `FFSTDP_UPD_LAT = 2`. It must match the datapath read + register stage.
- One sub-module, `ffstdp_issue_pipe`: parameterised {valid, addr} shift register of depth FFSTDP_UPD_LAT, with asynchronous clear.
- Address counter and FSM live in the top module.

## Test plan
- PRE_NUM=POST_NUM=4, START with IS_POS_IN=1, IS_TRAIN_IN=0, no PAUSE:
  - Reads 0..15 at cycles 1..16.
  - Writes 0..15 at cycles 3..18, with PRE_IDX/POST_IDX = addr[3:2]/addr[1:0].
  - DONE at cycle 19. IS_POS=1, IS_TRAIN=0 throughout.
- Same configuration, PAUSE=1 at cycles 5–7:
  - Read addr 4 issued at cycle 5 is withheld and reissued at cycle 8.
  - Write gap at cycles 7–9. DONE at cycle 22.
  - Every address written exactly once, in order.
- START pulsed again at cycles 4 and 18 during a sweep: ignored. Latched IS_POS/IS_TRAIN unchanged. Exactly 16 writes. A single DONE.
- RST asserted at cycle 10: next cycle all outputs are 0 and state is IDLE, with no write after reset. A new START then gives a full 16-address sweep from address 0.
- Back-to-back sweeps: START in the cycle after DONE is accepted. Second sweep's first read is at the following cycle, with the new IS_TRAIN_IN=1 latched.
- Reference model: check that SRAM_WE is never asserted with SRAM_WADDR equal to the SRAM_RADDR of the same cycle while SRAM_RE=1.
